// File: rtl/seg_scan_scheduler_if.sv
// Display-scheduler port bundle: load strobe and live controls in, decoder/digit drive out.
// The master drives load, value, dp_mask and lz_blank; the scheduler drives the display side.
interface seg_scan_scheduler_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        lz_blank;
  logic        busy;
  logic [3:0]  hex;
  logic [3:0]  digs;
  logic        dp;
  logic        frame_start;

  modport master (
    output load, value, dp_mask, lz_blank,
    input  busy, hex, digs, dp, frame_start
  );

  modport slave (
    input  load, value, dp_mask, lz_blank,
    output busy, hex, digs, dp, frame_start
  );
endinterface

// File: rtl/seg_scan_scheduler.sv
// Four-digit scan of a 16-bit word through one shared hex decoder; blanking gap opens each slot.
// Outputs decode from registers only; a load is held pending until the next frame boundary, and loads are dropped while busy.
module seg_scan_scheduler #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg_scan_scheduler_if.slave  bus
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   active;
  logic [15:0]   pending;
  logic          busy_q;
  logic          frame_start_q;
  logic [3:0]    dp_mask_q;
  logic          lz_blank_q;

  logic          slot_end;
  logic          frame_end;
  logic          on_phase;
  logic          blanked;

  assign slot_end  = (cnt == CNT_MAX);
  assign frame_end = slot_end && (idx == 2'd3);
  assign on_phase  = (cnt >= CNT_BLANK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      idx           <= 2'd0;
      active        <= 16'h0000;
      pending       <= 16'h0000;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
      dp_mask_q     <= 4'b0000;
      lz_blank_q    <= 1'b0;
    end else begin
      dp_mask_q     <= bus.dp_mask;
      lz_blank_q    <= bus.lz_blank;
      frame_start_q <= frame_end;

      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CNT_ONE;
      end

      // The boundary takes priority: a load on the edge that clears busy is dropped,
      // while a load on a boundary with busy low waits for the following boundary.
      if (frame_end && busy_q) begin
        active <= pending;
        busy_q <= 1'b0;
      end else if (bus.load && !busy_q) begin
        pending <= bus.value;
        busy_q  <= 1'b1;
      end
    end
  end

  // Leading-zero blanking: digit i is dark when nibbles i..3 are all zero; digit 0 always shows.
  always_comb begin
    blanked = 1'b0;
    if (lz_blank_q) begin
      case (idx)
        2'd3:    blanked = (active[15:12] == 4'h0);
        2'd2:    blanked = (active[15:8]  == 8'h00);
        2'd1:    blanked = (active[15:4]  == 12'h000);
        default: blanked = 1'b0;
      endcase
    end
  end

  assign bus.hex         = active[{idx, 2'b00} +: 4];
  assign bus.digs        = (on_phase && !blanked) ? (4'b0001 << idx) : 4'b0000;
  assign bus.dp          = on_phase && !blanked && dp_mask_q[idx];
  assign bus.busy        = busy_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Scoreboard bench: expected per-cycle display state is queued by cycle number, a negedge monitor compares.
module tb_seg_scan_scheduler;
  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;

  typedef struct {
    int         t;
    logic [4:0] care;   // digs, hex, dp, busy, frame_start
    logic [3:0] digs;
    logic [3:0] hex;
    logic       dp;
    logic       busy;
    logic       fs;
    string      nm;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tcyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   t0;
  int   t1;
  exp_t exp_q[$];
  exp_t e;

  seg_scan_scheduler_if bus ();

  seg_scan_scheduler #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic push(input int t, input logic [4:0] care, input logic [3:0] digs,
                      input logic [3:0] hex, input logic dp, input logic busy,
                      input logic fs, input string nm);
    exp_t x;
    x.t = t; x.care = care; x.digs = digs; x.hex = hex;
    x.dp = dp; x.busy = busy; x.fs = fs; x.nm = nm;
    exp_q.push_back(x);
  endtask

  task automatic busy_at(input int t, input logic b, input string nm);
    push(t, 5'b00010, 4'h0, 4'h0, 1'b0, b, 1'b0, nm);
  endtask

  // Expands hand-written per-digit values (digit 3 in the top nibble) over a frame.
  task automatic push_frame(input int tf, input int ncyc, input logic [15:0] digs_on,
                            input logic [15:0] hexes, input logic [3:0] dp_on,
                            input int busy, input logic fs_first, input string nm);
    for (int k = 0; k < ncyc; k++) begin
      int         i;
      int         c;
      logic       on;
      logic [3:0] d;
      i  = k / CLK_DIV;
      c  = k % CLK_DIV;
      on = (c >= BLANK);
      d  = on ? digs_on[4*i +: 4] : 4'h0;
      push(tf + k, (busy < 0) ? 5'b11101 : 5'b11111, d, hexes[4*i +: 4],
           on && dp_on[i], (busy > 0), (k == 0) ? fs_first : 1'b0,
           $sformatf("%s_c%0d", nm, k));
    end
  endtask

  task automatic at_cycle(input int base, input int c);
    while (tcyc < base + c) @(negedge clk);
  endtask

  task automatic do_load(input int c, input logic [15:0] v);
    at_cycle(t0, c);
    bus.load  = 1'b1;
    bus.value = v;
    at_cycle(t0, c + 1);
    bus.load  = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].t <= tcyc) begin
        e = exp_q[i];
        tests++;
        if (e.t < tcyc) begin
          fails++;
          $display("FAIL %s: check skipped at cycle %0d, required at cycle %0d", e.nm, tcyc, e.t);
        end else if ((e.care[4] && bus.digs !== e.digs) || (e.care[3] && bus.hex !== e.hex) ||
                     (e.care[2] && bus.dp !== e.dp) || (e.care[1] && bus.busy !== e.busy) ||
                     (e.care[0] && bus.frame_start !== e.fs)) begin
          fails++;
          $display("FAIL %s: got digs=%b hex=%h dp=%b busy=%b fs=%b, want digs=%b hex=%h dp=%b busy=%b fs=%b (care %b)",
                   e.nm, bus.digs, bus.hex, bus.dp, bus.busy, bus.frame_start,
                   e.digs, e.hex, e.dp, e.busy, e.fs, e.care);
        end
        exp_q.delete(i);
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.value    = 16'h0000;
    bus.dp_mask  = 4'hF;
    bus.lz_blank = 1'b0;

    push(2, 5'b11111, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, "reset_idle");
    at_cycle(0, 4);
    rst_n       = 1'b1;
    bus.dp_mask = 4'h0;
    t0          = tcyc;

    // Frames 0..8 relative to release; digs/hex/dp per digit are hand-derived.
    push_frame(t0 +   0, 32, 16'h8421, 16'h0000, 4'b0100, -1, 1'b0, "f0_idle");
    push_frame(t0 +  32, 32, 16'h8421, 16'h1A3F, 4'b0100, -1, 1'b1, "f1_1a3f");
    push_frame(t0 +  64, 32, 16'h8421, 16'h2B4C, 4'b0000,  0, 1'b1, "f2_2b4c");
    push_frame(t0 +  96, 32, 16'h8421, 16'h2B4C, 4'b0000, -1, 1'b1, "f3_2b4c");
    push_frame(t0 + 128, 32, 16'h0001, 16'h0007, 4'b0000, -1, 1'b1, "f4_lz0007");
    push_frame(t0 + 160, 32, 16'h0001, 16'h0000, 4'b0000, -1, 1'b1, "f5_lz0000");
    push_frame(t0 + 192, 32, 16'h0421, 16'h0100, 4'b0000,  0, 1'b1, "f6_lz0100");
    push_frame(t0 + 224, 32, 16'h0421, 16'h0100, 4'b0000,  1, 1'b1, "f7_wait");
    push_frame(t0 + 256, 20, 16'h0421, 16'h0ABC, 4'b0000, -1, 1'b1, "f8_0abc");

    busy_at(t0 +   5, 1'b0, "busy_pre_load");
    busy_at(t0 +   6, 1'b1, "busy_rise");
    busy_at(t0 +  31, 1'b1, "busy_hold");
    busy_at(t0 +  32, 1'b0, "busy_clear");
    busy_at(t0 +  34, 1'b0, "busy_pre_2b4c");
    busy_at(t0 +  35, 1'b1, "busy_2b4c");
    busy_at(t0 +  41, 1'b1, "busy_after_5555");
    busy_at(t0 +  63, 1'b1, "busy_end_f1");
    busy_at(t0 + 100, 1'b0, "busy_pre_0007");
    busy_at(t0 + 101, 1'b1, "busy_0007");
    busy_at(t0 + 127, 1'b1, "busy_end_f3");
    busy_at(t0 + 128, 1'b0, "busy_f4");
    busy_at(t0 + 131, 1'b1, "busy_0000");
    busy_at(t0 + 159, 1'b1, "busy_end_f4");
    busy_at(t0 + 160, 1'b0, "busy_f5");
    busy_at(t0 + 163, 1'b1, "busy_0100");
    busy_at(t0 + 191, 1'b1, "busy_end_f5");
    busy_at(t0 + 256, 1'b0, "busy_7777_dropped");
    busy_at(t0 + 260, 1'b0, "busy_pre_9999");
    busy_at(t0 + 261, 1'b1, "busy_9999");
    busy_at(t0 + 275, 1'b1, "busy_before_rst");
    for (int k = 276; k < 279; k++)
      push(t0 + k, 5'b11111, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, $sformatf("midrst_c%0d", k));

    at_cycle(t0, 5);
    bus.dp_mask = 4'b0100;
    do_load(5, 16'h1A3F);
    do_load(34, 16'h2B4C);
    do_load(40, 16'h5555);
    at_cycle(t0, 64);
    bus.dp_mask = 4'b0000;
    at_cycle(t0, 96);
    bus.lz_blank = 1'b1;
    do_load(100, 16'h0007);
    do_load(130, 16'h0000);
    do_load(162, 16'h0100);
    do_load(223, 16'h0ABC);
    do_load(255, 16'h7777);
    do_load(260, 16'h9999);

    // Reset lands early in cycle 276, during digit 2's ON phase with 9999 pending.
    at_cycle(t0, 275);
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.dp_mask  = 4'h0;
    bus.lz_blank = 1'b0;
    at_cycle(t0, 279);
    rst_n = 1'b1;
    t1    = tcyc;

    push_frame(t1 +  0, 32, 16'h8421, 16'h0000, 4'b0000, 0, 1'b0, "post_rst_f0");
    push_frame(t1 + 32, 32, 16'h8421, 16'h0000, 4'b0000, 0, 1'b1, "post_rst_f1");

    at_cycle(t1, 66);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: never checked, required at cycle %0d (now %0d)", e.nm, e.t, tcyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
